// File: rtl/t07_fpu_writeback.sv
// t07_fpu_writeback: queues FPU results and routes each to the integer or FPU register-file write port, tracking sticky fflags.
module t07_fpu_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fpuValid_i,
    output logic        fpuReady_o,
    input  logic [31:0] fpuResult_i,
    input  logic [4:0]  fpuOp_i,
    input  logic [4:0]  fpuRd_i,
    input  logic [4:0]  fpuFlags_i,
    input  logic        cpuRegWrite_i,
    output logic        intWriteEn_o,
    output logic [4:0]  intWriteAddr_o,
    output logic [31:0] intWriteData_o,
    output logic        fpWriteEn_o,
    output logic [4:0]  fpWriteAddr_o,
    output logic [31:0] fpWriteData_o,
    input  logic        fflagsClr_i,
    output logic [4:0]  fflags_o,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   res_q [DEPTH];
    logic [4:0]    rd_q  [DEPTH];
    logic          int_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, nonempty, head_int, head_rd_nz, int_we, fp_we;

    assign nonempty   = count != '0;
    assign fpuReady_o = count < (AW+1)'(DEPTH);
    assign push       = fpuValid_i && fpuReady_o;
    assign head_int   = int_q[rd_ptr];
    assign head_rd_nz = rd_q[rd_ptr] != 5'd0;
    // Int writes to x0 are dropped and popped without waiting for the port.
    assign int_we     = nonempty && head_int && head_rd_nz && !cpuRegWrite_i;
    assign fp_we      = nonempty && !head_int;
    assign pop        = nonempty && !(head_int && head_rd_nz && cpuRegWrite_i);
    assign busy_o     = nonempty;

    assign intWriteEn_o   = int_we;
    assign intWriteAddr_o = int_we ? rd_q[rd_ptr]  : 5'd0;
    assign intWriteData_o = int_we ? res_q[rd_ptr] : 32'd0;
    assign fpWriteEn_o    = fp_we;
    assign fpWriteAddr_o  = fp_we ? rd_q[rd_ptr]  : 5'd0;
    assign fpWriteData_o  = fp_we ? res_q[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            res_q[wr_ptr] <= fpuResult_i;
            rd_q[wr_ptr]  <= fpuRd_i;
            int_q[wr_ptr] <= fpuOp_i inside {5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd23};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fflags_o <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            if (push) fflags_o <= (fflagsClr_i ? 5'd0 : fflags_o) | fpuFlags_i;
            else if (fflagsClr_i) fflags_o <= 5'd0;
        end
    end
endmodule

// File: tb/tb_t07_fpu_writeback.sv
// tb_t07_fpu_writeback: directed checks of routing, int-port contention, back-pressure, x0 drop, fflags and async reset.
module tb_t07_fpu_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        fpuValid_i;
    logic        fpuReady_o;
    logic [31:0] fpuResult_i;
    logic [4:0]  fpuOp_i;
    logic [4:0]  fpuRd_i;
    logic [4:0]  fpuFlags_i;
    logic        cpuRegWrite_i;
    logic        intWriteEn_o;
    logic [4:0]  intWriteAddr_o;
    logic [31:0] intWriteData_o;
    logic        fpWriteEn_o;
    logic [4:0]  fpWriteAddr_o;
    logic [31:0] fpWriteData_o;
    logic        fflagsClr_i;
    logic [4:0]  fflags_o;
    logic        busy_o;
    int total = 0;
    int bad = 0;

    t07_fpu_writeback #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .fpuValid_i(fpuValid_i), .fpuReady_o(fpuReady_o),
        .fpuResult_i(fpuResult_i), .fpuOp_i(fpuOp_i), .fpuRd_i(fpuRd_i), .fpuFlags_i(fpuFlags_i),
        .cpuRegWrite_i(cpuRegWrite_i),
        .intWriteEn_o(intWriteEn_o), .intWriteAddr_o(intWriteAddr_o), .intWriteData_o(intWriteData_o),
        .fpWriteEn_o(fpWriteEn_o), .fpWriteAddr_o(fpWriteAddr_o), .fpWriteData_o(fpWriteData_o),
        .fflagsClr_i(fflagsClr_i), .fflags_o(fflags_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd, input logic [31:0] res, input logic [4:0] fl);
        fpuValid_i  = v;
        fpuOp_i     = op;
        fpuRd_i     = rd;
        fpuResult_i = res;
        fpuFlags_i  = fl;
    endtask

    initial begin
        rst = 1'b1;
        cpuRegWrite_i = 1'b0;
        fflagsClr_i = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 32'd0, 5'd0);
        #1;
        chk("rst_ready", fpuReady_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_fflags", fflags_o, 0);
        chk("rst_fpwe", fpWriteEn_o, 0);
        chk("rst_intwe", intWriteEn_o, 0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // FP path
        drive(1'b1, 5'd4, 5'd7, 32'h3F800000, 5'd0);
        #1;
        chk("fp_pre_we", fpWriteEn_o, 0);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 5'd0);
        #1;
        chk("fp_we", fpWriteEn_o, 1);
        chk("fp_addr", fpWriteAddr_o, 7);
        chk("fp_data", fpWriteData_o, 32'h3F800000);
        chk("fp_intwe", intWriteEn_o, 0);
        chk("fp_busy", busy_o, 1);
        cyc();
        chk("fp_busy_after", busy_o, 0);
        chk("fp_we_after", fpWriteEn_o, 0);

        // Int path with contention
        cpuRegWrite_i = 1'b1;
        drive(1'b1, 5'd19, 5'd5, 32'hFFFFFFFE, 5'd0);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_intwe", intWriteEn_o, 0);
            chk("stall_addr", intWriteAddr_o, 0);
            chk("stall_busy", busy_o, 1);
            cyc();
        end
        cpuRegWrite_i = 1'b0;
        #1;
        chk("int_we", intWriteEn_o, 1);
        chk("int_addr", intWriteAddr_o, 5);
        chk("int_data", intWriteData_o, 32'hFFFFFFFE);
        chk("int_fpwe", fpWriteEn_o, 0);
        cyc();
        chk("int_busy_after", busy_o, 0);

        // Full / back-pressure
        cpuRegWrite_i = 1'b1;
        drive(1'b1, 5'd15, 5'd1, 32'h11, 5'd0);
        cyc();
        drive(1'b1, 5'd16, 5'd2, 32'h22, 5'd0);
        cyc();
        drive(1'b1, 5'd4, 5'd3, 32'h33, 5'd0);
        #1;
        chk("full_ready", fpuReady_o, 0);
        chk("full_intwe", intWriteEn_o, 0);
        cyc();
        chk("full_ready_hold", fpuReady_o, 0);
        cpuRegWrite_i = 1'b0;
        #1;
        chk("bp_w1_we", intWriteEn_o, 1);
        chk("bp_w1_addr", intWriteAddr_o, 1);
        chk("bp_w1_data", intWriteData_o, 32'h11);
        cyc();
        chk("bp_ready_up", fpuReady_o, 1);
        chk("bp_w2_we", intWriteEn_o, 1);
        chk("bp_w2_addr", intWriteAddr_o, 2);
        chk("bp_w2_data", intWriteData_o, 32'h22);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 5'd0);
        #1;
        chk("bp_w3_fpwe", fpWriteEn_o, 1);
        chk("bp_w3_addr", fpWriteAddr_o, 3);
        chk("bp_w3_data", fpWriteData_o, 32'h33);
        chk("bp_w3_intwe", intWriteEn_o, 0);
        cyc();
        chk("bp_busy_after", busy_o, 0);

        // Int op to x0 is dropped regardless of port contention
        cpuRegWrite_i = 1'b1;
        drive(1'b1, 5'd16, 5'd0, 32'h5, 5'd0);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 5'd0);
        #1;
        chk("x0_intwe", intWriteEn_o, 0);
        chk("x0_fpwe", fpWriteEn_o, 0);
        chk("x0_busy", busy_o, 1);
        cyc();
        chk("x0_popped", busy_o, 0);
        cpuRegWrite_i = 1'b0;

        // fflags accumulate and clear
        drive(1'b1, 5'd4, 5'd9, 32'h1, 5'b00001);
        cyc();
        drive(1'b1, 5'd4, 5'd10, 32'h2, 5'b10000);
        #1;
        chk("ff_first", fflags_o, 5'b00001);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 5'd0);
        #1;
        chk("ff_accum", fflags_o, 5'b10001);
        cyc();
        fflagsClr_i = 1'b1;
        drive(1'b1, 5'd4, 5'd11, 32'h3, 5'b00100);
        cyc();
        fflagsClr_i = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 32'd0, 5'd0);
        #1;
        chk("ff_clr_push", fflags_o, 5'b00100);
        fflagsClr_i = 1'b1;
        cyc();
        fflagsClr_i = 1'b0;
        chk("ff_clr_only", fflags_o, 5'b00000);
        repeat (2) cyc();
        chk("ff_drained", busy_o, 0);

        // Async reset with two queued int entries
        cpuRegWrite_i = 1'b1;
        drive(1'b1, 5'd17, 5'd4, 32'h44, 5'b00010);
        cyc();
        drive(1'b1, 5'd18, 5'd6, 32'h66, 5'b00000);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 5'd0);
        chk("mr_busy", busy_o, 1);
        chk("mr_fflags", fflags_o, 5'b00010);
        #3;
        rst = 1'b1;
        #1;
        chk("mr_rst_busy", busy_o, 0);
        chk("mr_rst_ready", fpuReady_o, 1);
        chk("mr_rst_fflags", fflags_o, 0);
        chk("mr_rst_intwe", intWriteEn_o, 0);
        chk("mr_rst_intaddr", intWriteAddr_o, 0);
        chk("mr_rst_intdata", intWriteData_o, 0);
        chk("mr_rst_fpwe", fpWriteEn_o, 0);
        cpuRegWrite_i = 1'b0;
        cyc();
        chk("mr_hold_intwe", intWriteEn_o, 0);
        rst = 1'b0;
        cyc();
        chk("mr_post_intwe", intWriteEn_o, 0);
        chk("mr_post_fpwe", fpWriteEn_o, 0);
        chk("mr_post_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
